// File: rtl/sdram_pkg.sv
// Shared types, default sizes and the round-robin helper for the sdram_mp memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdram_pkg;

  // CLEAR sweeps the array to zero after reset; RUN serves client requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sdram_state_t;

  localparam int SDRAM_AW = 20;
  localparam int SDRAM_DW = 16;
  localparam int SDRAM_CH = 2;

  // Widest channel count the arbiter helper supports.
  localparam int RR_MAX = 8;

  // One-hot grant for the first requester found after 'last', wrapping at ch.
  // Bits at or above ch are never set.
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        last,
                                                input int                ch);
    logic [RR_MAX-1:0] gnt;
    logic [2:0]        ix;
    gnt = '0;
    ix  = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= ch) begin
        ix = 3'((int'(last) + k) % ch);
        if (gnt == '0 && req[ix]) gnt[ix] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sdram_rr_arb.sv
// Round-robin arbiter: one-hot grant among CH requesters, search starts after 'last'.
// Latency: grant is combinational from req/en; 'last' updates on the grant edge.
// Backpressure: en low suppresses every grant; ungranted requesters simply wait.
//
// Ports: clk, init_n (async active-low), req[CH], en -> gnt[CH] (one-hot), last.
module sdram_rr_arb
  import sdram_pkg::*;
#(
  parameter int CH = 2,
  parameter int LW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic [CH-1:0] req,
  input  logic          en,
  output logic [CH-1:0] gnt,
  output logic [LW-1:0] last
);

  logic [RR_MAX-1:0] gnt_w;
  logic [LW-1:0]     gidx;
  logic              unused_gnt_w;

  assign gnt_w        = rr_next(RR_MAX'(req), 3'(last), CH);
  assign gnt          = en ? gnt_w[CH-1:0] : '0;
  // Bits above CH are structurally zero; fold them so nothing dangles.
  assign unused_gnt_w = ^gnt_w;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt[i]) gidx = LW'(i);
    end
  end

  // Reset to CH-1 so channel 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      last <= LW'(CH - 1);
    end else if (|gnt) begin
      last <= gidx;
    end
  end

endmodule

// File: rtl/sdram_mp.sv
// Multi-channel on-chip memory: CH req/ack clients, one round-robin access per cycle.
// Latency: write completes at grant edge; read data + rvalid tag two cycles after ack.
// Backpressure: ack withheld until granted (req held); no grants while clearing.
//
// Ports: clk, init_n (async active-low); per channel req/we/addr/be/din -> ack;
//        shared dout with one-hot rvalid tag; ready = accepting requests.
// Build option: define SDRAM_CLEAR_EN to zero the whole array after every reset.
module sdram_mp
  import sdram_pkg::*;
#(
  parameter int AW = SDRAM_AW,
  parameter int DW = SDRAM_DW,
  parameter int CH = SDRAM_CH
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic [CH-1:0]        req,
  input  logic [CH-1:0]        we,
  input  logic [CH*AW-1:0]     addr,
  input  logic [CH*(DW/8)-1:0] be,
  input  logic [CH*DW-1:0]     din,
  output logic [CH-1:0]        ack,
  output logic [DW-1:0]        dout,
  output logic [CH-1:0]        rvalid,
  output logic                 ready
);

  localparam int BW = DW / 8;
  localparam int LW = (CH > 1) ? $clog2(CH) : 1;

`ifdef SDRAM_CLEAR_EN
  localparam sdram_state_t RST_STATE = CLEAR;
  logic [AW-1:0] clr_addr;
`else
  localparam sdram_state_t RST_STATE = RUN;
`endif

  sdram_state_t  state, state_nxt;
  logic          run;
  logic [CH-1:0] gnt;
  logic [LW-1:0] last_unused;

  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [BW-1:0] g_be;
  logic [DW-1:0] g_din;
  logic          wr_en, rd_en;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [CH-1:0] rd_tag;
  logic [DW-1:0] rd_dat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= RST_STATE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // Grants are also blocked while reset is held, so nothing is acked during it.
    run       = (state == RUN) && init_n;
`ifdef SDRAM_CLEAR_EN
    if (state == CLEAR && clr_addr == '1) state_nxt = RUN;
`endif
  end

  // Tracks the state register exactly, so it rises right after the last clear write.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) ready <= (RST_STATE == RUN);
    else         ready <= (state_nxt == RUN);
  end

`ifdef SDRAM_CLEAR_EN
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)              clr_addr <= '0;
    else if (state == CLEAR)  clr_addr <= clr_addr + 1'b1;
  end
`endif

  // ---------------------------------------------------------------- arbiter
  sdram_rr_arb #(.CH(CH), .LW(LW)) u_arb (
    .clk    (clk),
    .init_n (init_n),
    .req    (req),
    .en     (run),
    .gnt    (gnt),
    .last   (last_unused)
  );

  assign ack = gnt;

  // Select the granted channel's request fields.
  always_comb begin
    g_addr = '0;
    g_we   = 1'b0;
    g_be   = '0;
    g_din  = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt[k]) begin
        g_addr = addr[k*AW +: AW];
        g_we   = we[k];
        g_be   = be[k*BW +: BW];
        g_din  = din[k*DW +: DW];
      end
    end
  end

  assign wr_en = (|gnt) &  g_we;
  assign rd_en = (|gnt) & ~g_we;

  // ---------------------------------------------------------------- storage
  // Contents are deliberately not reset; only the optional sweep zeroes them.
  always_ff @(posedge clk) begin
`ifdef SDRAM_CLEAR_EN
    if (state == CLEAR) mem[clr_addr] <= '0;
`endif
    if (wr_en) begin
      for (int i = 0; i < BW; i++) begin
        if (g_be[i]) mem[g_addr][i*8 +: 8] <= g_din[i*8 +: 8];
      end
    end
  end

  // Two-stage read: array read at the grant edge, then the output register.
  // Reset drops the tags, discarding any read still in flight.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      rd_tag <= '0;
      rd_dat <= '0;
      rvalid <= '0;
      dout   <= '0;
    end else begin
      rd_tag <= rd_en ? gnt : '0;
      if (rd_en) rd_dat <= mem[g_addr];
      rvalid <= rd_tag;
      if (|rd_tag) dout <= rd_dat;
    end
  end

endmodule

// File: tb/tb_sdram_mp.sv
module tb_sdram_mp;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int BW = DW / 8;
  localparam int N  = 1 << AW;
`ifdef SDRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              init_n = 1'b0;
  logic [CH-1:0]     req = '0;
  logic [CH-1:0]     we = '0;
  logic [CH*AW-1:0]  addr = '0;
  logic [CH*BW-1:0]  be = '0;
  logic [CH*DW-1:0]  din = '0;
  logic [CH-1:0]     ack;
  logic [DW-1:0]     dout;
  logic [CH-1:0]     rvalid;
  logic              ready;

  sdram_mp #(.AW(AW), .DW(DW), .CH(CH)) dut (
    .clk    (clk),
    .init_n (init_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .be     (be),
    .din    (din),
    .ack    (ack),
    .dout   (dout),
    .rvalid (rvalid),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct {
    int            due;
    int            ch;
    logic [DW-1:0] dat;
    logic [DW-1:0] msk;
  } rd_t;

  logic [7:0] m_mem   [N][BW];
  bit         m_known [N][BW];
  int         m_last  = CH - 1;
  int         cyc     = 0;
  int         rel_cnt = 0;
  rd_t        rq[$];

  // Count clock edges, and edges since reset was last seen released.
  always @(posedge clk) begin
    cyc++;
    if (!init_n) rel_cnt = 0;
    else         rel_cnt++;
  end

  always @(negedge clk) begin
    logic [CH-1:0] e_ack, e_rv;
    logic          e_rdy;
    int            gc, a;
    rd_t           e;
    gc = -1;
    e_ack = '0;
    e_rv = '0;
    if (!init_n) begin
      rq.delete();
      m_last = CH - 1;
      if (CLR) begin
        for (int i = 0; i < N; i++)
          for (int b = 0; b < BW; b++) begin
            m_mem[i][b] = 8'h00;
            m_known[i][b] = 1'b1;
          end
      end
      e_rdy = !CLR;
    end else begin
      e_rdy = CLR ? (rel_cnt >= N) : 1'b1;
    end
    chk("ready", ready, e_rdy);

    // Round-robin: first requester after the last granted channel.
    if (init_n && e_rdy) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (gc < 0 && req[c]) gc = c;
      end
    end
    if (gc >= 0) e_ack[gc] = 1'b1;
    chk("ack", ack, e_ack);

    if (gc >= 0) begin
      m_last = gc;
      a = int'(addr[gc*AW +: AW]);
      if (we[gc]) begin
        for (int b = 0; b < BW; b++) begin
          if (be[gc*BW + b]) begin
            m_mem[a][b] = din[gc*DW + b*8 +: 8];
            m_known[a][b] = 1'b1;
          end
        end
      end else begin
        e.due = cyc + 2;
        e.ch  = gc;
        for (int b = 0; b < BW; b++) begin
          e.dat[b*8 +: 8] = m_mem[a][b];
          e.msk[b*8 +: 8] = m_known[a][b] ? 8'hFF : 8'h00;
        end
        rq.push_back(e);
      end
    end

    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      e_rv[e.ch] = 1'b1;
      chk("dout", dout & e.msk, e.dat & e.msk);
    end
    chk("rvalid", rvalid, e_rv);
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic [DW-1:0] d);
    we[c]            = w;
    addr[c*AW +: AW] = a;
    be[c*BW +: BW]   = b;
    din[c*DW +: DW]  = d;
    req[c]           = 1'b1;
  endtask

  // Single access on one channel; returns the ack cycle, request dropped after.
  task automatic access(input int c, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic [DW-1:0] d, output int t);
    sync();
    set_ch(c, w, a, b, d);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[c]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: ch%0d got no ack expected ack within 20 cycles", c);
    end
    @(posedge clk);
    #1;
    req[c] = 1'b0;
  endtask

  task automatic wait_ack(input int c, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[c]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: ch%0d got no ack expected ack within 20 cycles", c);
    end
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin
    int t, n, rdy_at;
    int cnt [CH];
    logic [CH-1:0] ak [8];
    logic [CH-1:0] rv [8];
    logic [CH-1:0] a_seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, '0);
    chk("rst_rvalid", rvalid, '0);
    chk("rst_dout", dout, '0);
    chk("rst_ready", ready, !CLR);

    init_n = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("ready_latency", n, CLR ? N : 0);

`ifdef SDRAM_CLEAR_EN
    for (int a = 0; a < N; a++) begin
      access(a % CH, 1'b0, AW'(a), '0, '0, t);
      @(negedge clk);
      @(negedge clk);
      chk("clear_zero", dout, 16'h0000);
    end
`endif

    // Give every word a known value.
    for (int a = 0; a < N; a++)
      access(0, 1'b1, AW'(a), '1, DW'($urandom), t);

    // Byte-lane merge on one word, then read back.
    access(0, 1'b1, 5'h05, 2'b11, 16'hBEEF, t);
    access(0, 1'b1, 5'h05, 2'b01, 16'h12AB, t);
    access(0, 1'b0, 5'h05, 2'b00, 16'h0000, t);
    @(negedge clk);
    chk("be_lat_t1", rvalid, '0);
    @(negedge clk);
    chk("be_rvalid", rvalid, 4'b0001);
    chk("be_dout", dout, 16'hBEAB);

    // Two channels contending for six cycles.
    sync();
    set_ch(0, 1'b0, 5'h05, '0, '0);
    set_ch(1, 1'b0, 5'h07, '0, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ak[i] = ack;
      rv[i] = rvalid;
      if (i == 5) begin
        @(posedge clk);
        #1;
        req[1:0] = 2'b00;
      end
    end
    chk("alt_first", ak[0], 4'b0010);
    for (int i = 1; i < 6; i++) chk("alt_toggle", ak[i] ^ ak[i-1], 4'b0011);
    for (int i = 0; i < 6; i++) chk("alt_rvalid", rv[i+2], ak[i]);

    // Read immediately after write to the same address.
    repeat (3) sync();
    set_ch(0, 1'b1, 5'h10, 2'b11, 16'hC3A5);
    wait_ack(0, t);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    set_ch(1, 1'b0, 5'h10, '0, '0);
    @(negedge clk);
    chk("raw_ack", ack, 4'b0010);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("raw_rvalid", rvalid, 4'b0010);
    chk("raw_dout", dout, 16'hC3A5);

    // Reset one cycle after a read ack: the read must vanish.
    repeat (3) sync();
    set_ch(0, 1'b0, 5'h05, '0, '0);
    wait_ack(0, t);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    init_n = 1'b0;
    @(posedge clk);
    #1;
    init_n = 1'b1;
    chk("rst2_dout", dout, '0);
    rdy_at = ready ? 0 : -1;
    for (int i = 0; i < N + 8; i++) begin
      @(posedge clk);
      #1;
      if (ready && rdy_at < 0) rdy_at = i + 1;
      chk("rst2_rvalid", rvalid, '0);
    end
    chk("rst2_ready_latency", rdy_at, CLR ? N : 0);

    // All four channels contending straight after reset.
    for (int c = 0; c < CH; c++) begin
      set_ch(c, 1'b0, AW'(c + 3), '0, '0);
      cnt[c] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ak[i] = ack;
      for (int c = 0; c < CH; c++) if (ack[c]) cnt[c]++;
      if (i == 7) begin
        @(posedge clk);
        #1;
        req = '0;
      end
    end
    for (int i = 0; i < 8; i++) chk("rr4_order", ak[i], 4'b0001 << (i % 4));
    for (int c = 0; c < CH; c++) chk("rr4_count", cnt[c], 2);

    // Randomized traffic with occasional withdrawals.
    repeat (3) sync();
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      a_seen = ack;
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (req[c] && a_seen[c]) begin
          req[c] = 1'b0;
          if ($urandom_range(1, 0) == 1)
            set_ch(c, 1'($urandom_range(1, 0)), AW'($urandom_range(N - 1, 0)),
                   BW'($urandom), DW'($urandom));
        end else if (req[c]) begin
          if ($urandom_range(19, 0) == 0) req[c] = 1'b0;
        end else if ($urandom_range(9, 0) < 4) begin
          set_ch(c, 1'($urandom_range(1, 0)), AW'($urandom_range(N - 1, 0)),
                 BW'($urandom), DW'($urandom));
        end
      end
    end
    req = '0;
    repeat (5) sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_mp.md
# sdram_mp

Multi-channel, parametrised on-chip memory that replaces the single-port 8-bit memory model behind the `sdram` name. It accepts independent read/write requests from up to `CH` clients through a req/ack handshake and serves one per clock through a round-robin arbiter. Writes honour per-byte enables, and reads return a fixed-latency, channel-tagged data beat. It sits between the CPU/video clients and the game memory image.

## Interface
- `AW`, 20, word address width; depth = 2^AW words.
- `DW`, 16, data width; multiple of 8, range 8..64; `BW = DW/8` byte lanes.
- `CH`, 2, number of client channels; range 1..8.
- `clk`  in  1  memory clock, ~100 MHz; all logic on the rising edge.
- `init_n`  in  1  reset; asynchronous assert, active-low; memory contents are not reset.
- `req`  in  CH  per-channel request; held high until the matching `ack`.
- `we`  in  CH  per-channel write (1) or read (0); sampled with `req`.
- `addr`  in  CH*AW  per-channel word address; channel k uses slice [k*AW +: AW].
- `be`  in  CH*BW  per-channel byte enables for writes; ignored on reads.
- `din`  in  CH*DW  per-channel write data.
- `ack`  out  CH  one-hot grant; combinational, high for exactly the accepting cycle.
- `dout`  out  DW  shared read data, valid when any `rvalid` bit is high.
- `rvalid`  out  CH  one-hot read-data strobe identifying the owning channel.
- `ready`  out  1  high once the block is accepting requests.

## Operation
- States: `CLEAR`, `RUN`. `init_n` low forces `CLEAR` when `SDRAM_CLEAR_EN` is defined, and `RUN` otherwise.
- `CLEAR`:
  - A counter `clr_addr` starts at 0 and writes all-zero words, one per cycle.
  - After writing address 2^AW-1 the block moves to `RUN`.
  - `ack` is forced to 0 in this state.
- `RUN`: each cycle the arbiter picks at most one requesting channel.
  - Search order starts at `last+1` mod CH and wraps around.
  - `last` updates only on a grant.
  - `last` resets to CH-1, so channel 0 wins the first contested cycle.
- Granted write: byte lane i of `memory[addr]` is written from `din` only where `be[i]`=1. An all-zero `be` is acked as a no-op.
- Granted read: memory is read at the grant edge. The word is registered into `dout` with `rvalid[k]` set.
- A request that is not granted waits. There is no starvation: any held `req` is granted within CH cycles.
- Dropping `req` before `ack` is legal and withdraws the request.
- Address wrap: none. The full address range is mapped.

## Timing
- Throughput: one access per cycle; back-to-back grants to the same or different channels are allowed.
- Read latency: `ack` in cycle T, then `dout`/`rvalid[k]` valid in cycle T+2 for exactly one cycle.
- Read after write, same address, write granted in cycle T: a read granted in cycle T+1 or later returns the new data.
- Writes complete at the grant edge.
- Reset values:
  - `ack`=0, `rvalid`=0, `dout`=0.
  - `ready`=0 when clearing is enabled, 1 when it is not.
  - `last`=CH-1, `clr_addr`=0.
- Reset mid-operation:
  - In-flight reads are discarded; `rvalid` is not raised for them.
  - A clear in progress restarts from 0 after `init_n` rises.
- `ready` = (state == `RUN`), registered. It rises in the cycle after the final clear write, i.e. 2^AW cycles after `init_n` rises.

## Configuration
- `SDRAM_CLEAR_EN` defined:
  - The `CLEAR` sweep runs after every reset.
  - Memory reads zero until written.
- `SDRAM_CLEAR_EN` undefined:
  - There is no clear counter.
  - `ready`=1 from reset release, and the first grant is possible in the first cycle after `init_n` rises.
  - Initial memory contents are undefined (X in simulation).

## Structure
- Package `sdram_pkg`:
  - State enum `sdram_state_t` (`CLEAR`, `RUN`).
  - Default constants `SDRAM_AW`, `SDRAM_DW`, `SDRAM_CH`.
  - Function `rr_next(req, last)` returning the one-hot grant.
- Sub-module `sdram_rr_arb`: parametrised by `CH`; inputs `clk`, `init_n`, `req`, `en`; outputs one-hot `gnt` and the registered `last`.
- The top level holds the memory array, clear counter, byte-lane write logic and the two-stage read pipeline with channel tag.

## Test plan
- Reset release with `SDRAM_CLEAR_EN`, AW=4 → `ready` rises exactly 16 cycles after `init_n` rises; reads of all 16 addresses return 0.
- Channel 0 writes 0xBEEF to address 0x00005 with `be`=2'b11, then writes 0x12AB with `be`=2'b01 → read of 0x00005 returns 0xBE AB in cycle T+2 with `rvalid`=2'b01.
- Channels 0 and 1 both hold reads for 6 cycles, CH=2 → `ack` alternates 01,10,01,10…; `rvalid` follows 2 cycles later with the same sequence.
- Write to 0x00010 granted in cycle T, read to 0x00010 granted in cycle T+1 → `dout` holds the new data in cycle T+3.
- `init_n` pulsed low one cycle after a read `ack` → `rvalid` never asserts for that read; `dout`=0; clear sweep restarts.
- CH=4, all four requesting continuously for 8 cycles → each channel is acked exactly twice, in order 0,1,2,3,0,1,2,3.
